// File: rtl/four_bit_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// four_bit_serial_subtractor_if : request/result bundle for the serial subtractor
// Revision: 1.0
// ============================================================================
interface four_bit_serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic [WIDTH-1:0] D;
   logic             Bout;
   logic             busy;
   logic             done;

   modport master (output start, A, B, Bin, input D, Bout, busy, done);
   modport slave  (input start, A, B, Bin, output D, Bout, busy, done);
endinterface
`default_nettype wire

// File: rtl/four_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// four_bit_serial_subtractor : bit-serial D = A - B - Bin, LSB first
// Revision: 1.0
// ============================================================================
module four_bit_serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   four_bit_serial_subtractor_if.slave  bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             w_a, w_b, w_dbit, w_rnext;
   logic [WIDTH-1:0] w_res_shift;

   // Full-subtractor cell on the current LSB pair
   assign w_a         = a_sh_q[0];
   assign w_b         = b_sh_q[0];
   assign w_dbit      = w_a ^ w_b ^ r_q;
   assign w_rnext     = (~w_a & w_b) | (~(w_a ^ w_b) & r_q);
   assign w_res_shift = {w_dbit, res_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      bout_d  = bout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_sh_d  = bus.A;
               b_sh_d  = bus.B;
               r_d     = bus.Bin;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = w_res_shift;
            r_d    = w_rnext;
            cnt_d  = cnt_q + CW'(1);
            // Publish only the complete result, never partial bits
            if (cnt_q == C_LAST) begin
               d_d     = w_res_shift;
               bout_d  = w_rnext;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         r_q     <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.D    = d_q;
   assign bus.Bout = bout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule
`default_nettype wire

// File: tb/tb_four_bit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// tb_four_bit_serial_subtractor : directed self-checking bench
// Revision: 1.0
// ============================================================================
module tb_four_bit_serial_subtractor;
   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   edge_cnt;
   int   accept_edge;
   logic [3:0] last_d;
   logic       last_b;

   four_bit_serial_subtractor_if #(.WIDTH(4)) bus ();

   four_bit_serial_subtractor #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full operation; inputs change #1 after an edge, outputs sampled there too.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                         input logic [3:0] exp_d, input logic exp_b,
                         input bit keep_start, input bit scramble, input string tag);
      int  lat;
      int  busy_n;
      bit  seen;
      bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
      @(posedge clk); #1;
      accept_edge = edge_cnt;
      check({tag, ".busy_rise"}, 32'(bus.busy), 32'd1);
      if (!keep_start) bus.start = 1'b0;
      if (scramble) begin bus.A = 4'd0; bus.B = 4'd15; bus.Bin = 1'b1; end
      busy_n = 1; seen = 1'b0; lat = 0;
      for (int k = 1; k <= 12 && !seen; k++) begin
         if (scramble) bus.start = k[0];
         @(posedge clk); #1;
         if (bus.busy) busy_n++;
         if (bus.done) begin
            seen = 1'b1;
            lat  = k;
         end else begin
            check({tag, ".d_stable"}, {27'd0, bus.Bout, bus.D}, {27'd0, last_b, last_d});
         end
      end
      check({tag, ".latency"}, 32'(lat), 32'd4);
      check({tag, ".D"}, 32'(bus.D), 32'(exp_d));
      check({tag, ".Bout"}, 32'(bus.Bout), 32'(exp_b));
      if (scramble) bus.start = 1'b1;
      @(posedge clk); #1;
      if (scramble) bus.start = 1'b0;
      check({tag, ".done_fall"}, 32'(bus.done), 32'd0);
      check({tag, ".busy_fall"}, 32'(bus.busy), 32'd0);
      check({tag, ".busy_cycles"}, 32'(busy_n), 32'd5);
      check({tag, ".D_hold"}, 32'(bus.D), 32'(exp_d));
      last_d = exp_d;
      last_b = exp_b;
   endtask

   initial begin
      int prev_accept;
      int diff;
      bit extra_done;
      errors = 0; checks = 0; edge_cnt = 0;
      last_d = 4'd0; last_b = 1'b0;
      bus.start = 1'b0; bus.A = 4'd0; bus.B = 4'd0; bus.Bin = 1'b0;
      rst = 1'b1;
      #1;
      check("reset.D", 32'(bus.D), 32'd0);
      check("reset.Bout", 32'(bus.Bout), 32'd0);
      check("reset.busy", 32'(bus.busy), 32'd0);
      check("reset.done", 32'(bus.done), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Basic directed vectors
      run_op(4'd9, 4'd3, 1'b0, 4'd6,  1'b0, 1'b0, 1'b0, "op_9_3");
      run_op(4'd3, 4'd9, 1'b0, 4'hA,  1'b1, 1'b0, 1'b0, "op_3_9");
      run_op(4'd0, 4'd0, 1'b1, 4'hF,  1'b1, 1'b0, 1'b0, "op_0_0_b");
      run_op(4'd8, 4'd7, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, "op_8_7_b");

      // Inputs and start disturbed while the operation is in flight
      run_op(4'd15, 4'd1, 1'b0, 4'hE, 1'b0, 1'b0, 1'b1, "op_scramble");
      extra_done = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) extra_done = 1'b1;
      end
      check("scramble.no_extra", 32'(extra_done), 32'd0);

      // start held high: back-to-back operations every 6 edges
      run_op(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, "hold0");
      prev_accept = accept_edge;
      run_op(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, "hold1");
      check("hold.spacing1", 32'(accept_edge - prev_accept), 32'd6);
      prev_accept = accept_edge;
      run_op(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, "hold2");
      check("hold.spacing2", 32'(accept_edge - prev_accept), 32'd6);

      // Reset in the middle of an operation
      bus.A = 4'd12; bus.B = 4'd4; bus.Bin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort.D", 32'(bus.D), 32'd0);
      check("abort.Bout", 32'(bus.Bout), 32'd0);
      check("abort.busy", 32'(bus.busy), 32'd0);
      check("abort.done", 32'(bus.done), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      last_d = 4'd0; last_b = 1'b0;
      extra_done = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) extra_done = 1'b1;
      end
      check("abort.no_done", 32'(extra_done), 32'd0);
      run_op(4'd12, 4'd4, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, "op_after_abort");

      // Exhaustive sweep against integer arithmetic
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               diff = a - b - c;
               run_op(4'(a), 4'(b), 1'(c), 4'(diff & 15), (diff < 0) ? 1'b1 : 1'b0,
                      1'b0, 1'b0, $sformatf("sweep_%0d_%0d_%0d", a, b, c));
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/four_bit_serial_subtractor.md
# four_bit_serial_subtractor

Bit-serial subtractor: computes D = A − B − Bin over WIDTH clock cycles, one bit per cycle, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtraction counterpart of the ripple-carry adders in the arithmetic library. It trades latency for area, and a start/busy/done handshake sequences it. Intended users are multi-cycle datapaths where a WIDTH-wide ripple subtractor is not justified.

## Interface
- WIDTH, 4, operand/result width in bits; must be ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; sampled on the accepting edge only
- B  input  WIDTH  subtrahend; sampled on the accepting edge only
- Bin  input  1  borrow in; sampled on the accepting edge only
- D  output  WIDTH  difference (A − B − Bin) mod 2^WIDTH; registered; holds until the next completion
- Bout  output  1  borrow out; 1 iff A < B + Bin; registered; holds with D
- busy  output  1  high in SHIFT and DONE
- done  output  1  single-cycle completion pulse

## Operation
- Reset behaviour:
  - state = IDLE; D = 0; Bout = 0; busy = 0; done = 0.
  - Operand shift registers, result shift register, borrow flop and bit counter are all cleared.
- State machine, states IDLE / SHIFT / DONE:
  - IDLE: when start = 1 on an edge, latch A, B into shift registers, load borrow ← Bin and count ← 0, then go to SHIFT. If start = 0, stay in IDLE.
  - SHIFT: each edge processes the current LSB pair (a, b) with borrow r:
    - d = a ^ b ^ r
    - r ← (~a & b) | (~(a ^ b) & r)
    - d is shifted into the result register from the MSB side; the operand registers shift right; count increments.
    - On the edge processing bit WIDTH−1, D ← the complete result (including that final bit), Bout ← the final borrow, and the state goes to DONE.
  - DONE: done = 1 for this state's single cycle. The next edge returns to IDLE unconditionally.
- start is ignored in SHIFT and DONE; there is no queuing. A request held high through DONE is accepted on the first edge in IDLE.
- A, B and Bin may change freely after the accepting edge without affecting the result in flight.
- D and Bout change only on the completion edge. They never expose partial results.
- Arithmetic:
  - Modulo 2^WIDTH two's-complement difference.
  - Bout is the unsigned borrow: Bout = 1 exactly when A − B − Bin < 0 as unsigned integers.
- Reset asserted mid-operation aborts immediately: no done pulse, and D/Bout are cleared to 0.

## Timing
- Edge E0 (start accepted in IDLE): busy rises after E0.
- Edges E1 … E_WIDTH: one bit each. E_WIDTH updates D and Bout and enters DONE; done = 1 during the cycle after E_WIDTH.
- Edge E_WIDTH+1: back to IDLE; busy and done fall.
- Latency from accepting edge to done high: WIDTH edges (4 for the default).
- Minimum spacing between accepted starts: WIDTH + 2 edges (6 for the default).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- A=9, B=3, Bin=0, start for 1 cycle -> done pulses exactly 4 edges after acceptance; D=6, Bout=0; busy high for exactly 5 cycles.
- A=3, B=9, Bin=0 -> D=10 (0xA), Bout=1. Then A=0, B=0, Bin=1 -> D=15, Bout=1. Then A=8, B=7, Bin=1 -> D=0, Bout=0.
- Accept A=15, B=1, Bin=0, then drive A=0, B=15 and pulse start during SHIFT and DONE -> start is ignored, operand changes have no effect, D=14, Bout=0, and only one done pulse occurs.
- start held high continuously with A=5, B=2, Bin=0 -> an operation is accepted every 6 edges; each completion gives D=3, Bout=0 with one done pulse.
- Assert rst after 2 SHIFT edges of A=12, B=4 -> D=0, Bout=0, busy=0 immediately; no done pulse. After release, a new A=12, B=4, Bin=0 gives D=8, Bout=0.
- Exhaustive sweep of all 512 (A, B, Bin) combinations -> D and Bout match (A − B − Bin) mod 16 and the unsigned borrow on every done pulse; D stays stable between pulses.
